// File: rtl/isp_pkg.sv
// Shared ISP definitions: test-pattern mode codes, TPG FSM encoding and the
// colour-bar table used by the RAW test-pattern generator.
package isp_pkg;

  localparam logic [1:0] TPG_BARS  = 2'd0;
  localparam logic [1:0] TPG_RAMP  = 2'd1;
  localparam logic [1:0] TPG_FLAT  = 2'd2;
  localparam logic [1:0] TPG_CHECK = 2'd3;

  // Width of the raster counters; wide enough for any practical frame size.
  localparam int TPG_CW = 16;

  typedef enum logic {
    TPG_IDLE = 1'b0,
    TPG_RUN  = 1'b1
  } tpg_state_e;

  // {R,G,B} per bar, left to right: W, Y, C, G, M, R, B, K.
  localparam logic [23:0] TPG_BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // RGGB: R on (even y, even x), B on (odd y, odd x), G elsewhere.
  function automatic logic [7:0] tpg_bar_sample(input logic [2:0] bar,
                                                input logic x_odd,
                                                input logic y_odd);
    logic [23:0] rgb;
    rgb = TPG_BAR_RGB[bar];
    case ({y_odd, x_odd})
      2'b00:   return rgb[23:16];
      2'b11:   return rgb[7:0];
      default: return rgb[15:8];
    endcase
  endfunction

endpackage

// File: rtl/isp_tpg_timing.sv
// Raster timing for the RAW TPG: IDLE/RUN FSM, h/v counters, raw sync/den
// decodes and active-window coordinates. Outputs are ungated position decodes.
module isp_tpg_timing
  import isp_pkg::*;
#(
  parameter int source_h = 1024,
  parameter int source_v = 1024,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 40,
  parameter int H_FP     = 40,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 4,
  parameter int V_FP     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output tpg_state_e o_state,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_den,
  output logic       o_frame_start,
  output logic       o_frame_last,
  output logic [7:0] o_x,
  output logic [3:0] o_y
);

  localparam int H_TOTAL = H_SYNC + H_BP + source_h + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + source_v + V_FP;

  localparam logic [TPG_CW-1:0] H_LAST     = TPG_CW'(H_TOTAL - 1);
  localparam logic [TPG_CW-1:0] V_LAST     = TPG_CW'(V_TOTAL - 1);
  localparam logic [TPG_CW-1:0] H_SYNC_END = TPG_CW'(H_SYNC);
  localparam logic [TPG_CW-1:0] V_SYNC_END = TPG_CW'(V_SYNC);
  localparam logic [TPG_CW-1:0] H_ACT0     = TPG_CW'(H_SYNC + H_BP);
  localparam logic [TPG_CW-1:0] H_ACT1     = TPG_CW'(H_SYNC + H_BP + source_h);
  localparam logic [TPG_CW-1:0] V_ACT0     = TPG_CW'(V_SYNC + V_BP);
  localparam logic [TPG_CW-1:0] V_ACT1     = TPG_CW'(V_SYNC + V_BP + source_v);

  tpg_state_e        r_state;
  tpg_state_e        w_state_nxt;
  logic [TPG_CW-1:0] r_h_cnt;
  logic [TPG_CW-1:0] r_v_cnt;
  logic [TPG_CW-1:0] w_h_nxt;
  logic [TPG_CW-1:0] w_v_nxt;
  logic              w_h_last;
  logic              w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= TPG_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
    end
  end

  // A frame, once started, always runs to its last position; enable is only
  // consulted there.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    case (r_state)
      TPG_IDLE: begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (enable) w_state_nxt = TPG_RUN;
      end
      TPG_RUN: begin
        if (w_h_last) begin
          w_h_nxt = '0;
          if (w_v_last) begin
            w_v_nxt = '0;
            if (!enable) w_state_nxt = TPG_IDLE;
          end else begin
            w_v_nxt = r_v_cnt + 1'b1;
          end
        end else begin
          w_h_nxt = r_h_cnt + 1'b1;
        end
      end
      default: w_state_nxt = TPG_IDLE;
    endcase
  end

  assign o_state       = r_state;
  assign o_hsync       = (r_h_cnt < H_SYNC_END);
  assign o_vsync       = (r_v_cnt < V_SYNC_END);
  assign o_den         = (r_h_cnt >= H_ACT0) && (r_h_cnt < H_ACT1) &&
                         (r_v_cnt >= V_ACT0) && (r_v_cnt < V_ACT1);
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_frame_last  = w_h_last && w_v_last;
  assign o_x           = 8'(r_h_cnt - H_ACT0);
  assign o_y           = 4'(r_v_cnt - V_ACT0);

endmodule

// File: rtl/isp_raw_tpg.sv
// Bayer RAW (RGGB) test-pattern generator with programmable frame timing.
// Optional ISP_TPG_SCROLL_EN: ramp and colour bars scroll with frame_cnt.
module isp_raw_tpg
  import isp_pkg::*;
#(
  parameter int source_h = 1024,
  parameter int source_v = 1024,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 40,
  parameter int H_FP     = 40,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 4,
  parameter int V_FP     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_mode,
  output logic       out_vsync,
  output logic       out_hsync,
  output logic       out_den,
  output logic [7:0] out_data,
  output logic [7:0] frame_cnt,
  output logic       frame_done
);

  localparam int                BAR_W    = source_h / 8;
  localparam logic [TPG_CW-1:0] BAR_LAST = TPG_CW'(BAR_W - 1);

  tpg_state_e w_state;
  logic       w_run;
  logic       w_hsync_raw, w_vsync_raw, w_den_raw;
  logic       w_start_raw, w_last_raw;
  logic       w_hsync, w_vsync, w_den, w_frame_start, w_frame_last;
  logic [7:0] w_x;
  logic [3:0] w_y;
  logic       w_unused_y;
  logic [7:0] w_scroll;
  logic [7:0] w_pix;

  logic [1:0]        r_mode;
  logic [7:0]        r_offset;
  logic [2:0]        r_start_bar;
  logic [2:0]        r_bar_idx;
  logic [TPG_CW-1:0] r_bar_px;
  logic              r_vsync, r_hsync, r_den, r_frame_done;
  logic [7:0]        r_data;
  logic [7:0]        r_frame_cnt;

  isp_tpg_timing #(
    .source_h(source_h), .source_v(source_v),
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .o_state      (w_state),
    .o_hsync      (w_hsync_raw),
    .o_vsync      (w_vsync_raw),
    .o_den        (w_den_raw),
    .o_frame_start(w_start_raw),
    .o_frame_last (w_last_raw),
    .o_x          (w_x),
    .o_y          (w_y)
  );

  // Counters sit at (0,0) while idle, so every decode is qualified by RUN.
  assign w_run         = (w_state == TPG_RUN);
  assign w_hsync       = w_run && w_hsync_raw;
  assign w_vsync       = w_run && w_vsync_raw;
  assign w_den         = w_run && w_den_raw;
  assign w_frame_start = w_run && w_start_raw;
  assign w_frame_last  = w_run && w_last_raw;
  assign w_unused_y    = ^w_y[2:1];

`ifdef ISP_TPG_SCROLL_EN
  assign w_scroll = r_frame_cnt;
`else
  assign w_scroll = 8'h00;
`endif

  always_comb begin
    w_pix = 8'h00;
    case (r_mode)
      TPG_BARS:  w_pix = tpg_bar_sample(r_bar_idx, w_x[0], w_y[0]);
      TPG_RAMP:  w_pix = w_x + r_offset;
      TPG_FLAT:  w_pix = 8'h80;
      TPG_CHECK: w_pix = (w_x[3] ^ w_y[3]) ? 8'hFF : 8'h00;
      default:   w_pix = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode       <= TPG_BARS;
      r_offset     <= 8'h00;
      r_start_bar  <= 3'd0;
      r_bar_idx    <= 3'd0;
      r_bar_px     <= '0;
      r_vsync      <= 1'b0;
      r_hsync      <= 1'b0;
      r_den        <= 1'b0;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'h00;
    end else begin
      if (w_frame_start) begin
        r_mode      <= pattern_mode;
        r_offset    <= w_scroll;
        r_start_bar <= w_scroll[7:5];
      end
      // Bar index tracks the current pixel; it rewinds outside the active window.
      if (!w_den) begin
        r_bar_px  <= '0;
        r_bar_idx <= r_start_bar;
      end else if (r_bar_px == BAR_LAST) begin
        r_bar_px  <= '0;
        r_bar_idx <= r_bar_idx + 1'b1;
      end else begin
        r_bar_px  <= r_bar_px + 1'b1;
      end
      r_vsync      <= w_vsync;
      r_hsync      <= w_hsync;
      r_den        <= w_den;
      r_data       <= w_den ? w_pix : 8'h00;
      r_frame_done <= w_frame_last;
      if (w_frame_last) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign out_vsync  = r_vsync;
  assign out_hsync  = r_hsync;
  assign out_den    = r_den;
  assign out_data   = r_data;
  assign frame_cnt  = r_frame_cnt;
  assign frame_done = r_frame_done;

endmodule
